// File: rtl/program_loader.sv
// program_loader: byte-stream to program memory loader.
// Assembles MSB-first bytes into words and writes them to consecutive addresses.
module program_loader #(
    parameter int P_SIZE = 6,
    parameter int I_SIZE = 24
) (
    input  logic              clk,
    input  logic              nReset,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic              wr_en,
    output logic [P_SIZE-1:0] wr_addr,
    output logic [I_SIZE-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [P_SIZE:0]   word_count
);

    localparam int BYTES = I_SIZE / 8;
    localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [BCW-1:0]    LAST_BYTE = BCW'(BYTES - 1);
    localparam logic [P_SIZE-1:0] ADDR_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WRITE,
        DONE
    } state_t;

    state_t            state_q;
    logic              ready_q;
    logic              wr_en_q;
    logic              busy_q;
    logic              done_q;
    logic              error_q;
    logic              last_q;
    logic [P_SIZE-1:0] addr_q;
    logic [I_SIZE-1:0] shift_q;
    logic [I_SIZE-1:0] data_q;
    logic [P_SIZE:0]   count_q;
    logic [BCW-1:0]    bcnt_q;

    logic              accept;
    logic [I_SIZE-1:0] shift_d;

    // Byte handshake and the word that results from shifting the byte in
    always_comb begin
        accept  = in_valid & ready_q;
        shift_d = I_SIZE'({shift_q, in_data});
    end

    // Load sequencer: collect bytes, emit one write per word, finish or fault
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            wr_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            last_q  <= 1'b0;
            addr_q  <= '0;
            shift_q <= '0;
            data_q  <= '0;
            count_q <= '0;
            bcnt_q  <= '0;
        end else begin
            wr_en_q <= 1'b0;
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q <= LOAD;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        error_q <= 1'b0;
                        addr_q  <= '0;
                        count_q <= '0;
                        bcnt_q  <= '0;
                        shift_q <= '0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        shift_q <= shift_d;
                        bcnt_q  <= bcnt_q + 1'b1;
                        if (bcnt_q == LAST_BYTE) begin
                            state_q <= WRITE;
                            ready_q <= 1'b0;
                            wr_en_q <= 1'b1;
                            data_q  <= shift_d;
                            last_q  <= in_last;
                        end else if (in_last) begin
                            // Stream ended mid-word: drop the partial word
                            state_q <= DONE;
                            ready_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            error_q <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    count_q <= count_q + 1'b1;
                    bcnt_q  <= '0;
                    if (last_q) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        error_q <= 1'b0;
                    end else if (addr_q == ADDR_MAX) begin
                        // Memory full before the stream ended
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        error_q <= 1'b1;
                        addr_q  <= '0;
                    end else begin
                        state_q <= LOAD;
                        ready_q <= 1'b1;
                        addr_q  <= addr_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign in_ready   = ready_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = addr_q;
    assign wr_data    = data_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign word_count = count_q;

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: randomized stream bench for program_loader.
// Expected writes come from a word-grouping model of the byte stream.
module tb_program_loader;

    localparam int P_SIZE = 6;
    localparam int I_SIZE = 24;
    localparam int BYTES  = I_SIZE / 8;
    localparam int DEPTH  = 1 << P_SIZE;

    logic              clk = 1'b0;
    logic              nReset = 1'b0;
    logic              start = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_valid = 1'b0;
    logic              in_last = 1'b0;
    logic              in_ready;
    logic              wr_en;
    logic [P_SIZE-1:0] wr_addr;
    logic [I_SIZE-1:0] wr_data;
    logic              busy;
    logic              done;
    logic              error;
    logic [P_SIZE:0]   word_count;

    program_loader #(
        .P_SIZE(P_SIZE),
        .I_SIZE(I_SIZE)
    ) dut (
        .clk        (clk),
        .nReset     (nReset),
        .start      (start),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;
    int acc_cyc = -1;
    int wr_cyc = -1;
    int done_cyc = -1;
    logic done_prev = 1'b0;

    int                wa[$];
    logic [I_SIZE-1:0] wd[$];
    logic [7:0]        sb[$];
    bit                sl[$];
    int                ea[$];
    logic [I_SIZE-1:0] ed[$];
    bit                e_err;
    int                e_wc;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Write monitor
    always @(negedge clk) begin
        if (wr_en) begin
            wa.push_back(int'(wr_addr));
            wd.push_back(wr_data);
            wr_cyc = cyc_cnt;
        end
        if (done && !done_prev) done_cyc = cyc_cnt;
        done_prev = done;
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Group the stream into words and decide how the load terminates
    function automatic void model();
        int addr = 0;
        int k = 0;
        logic [31:0] word = 0;
        ea.delete();
        ed.delete();
        e_err = 1'b0;
        e_wc = 0;
        foreach (sb[i]) begin
            word = (word << 8) | 32'(sb[i]);
            k++;
            if (k == BYTES) begin
                ea.push_back(addr);
                ed.push_back(word[I_SIZE-1:0]);
                e_wc++;
                k = 0;
                word = 0;
                if (sl[i]) begin
                    e_err = 1'b0;
                    return;
                end
                if (e_wc == DEPTH) begin
                    e_err = 1'b1;
                    return;
                end
                addr++;
            end else if (sl[i]) begin
                e_err = 1'b1;
                return;
            end
        end
    endfunction

    task automatic clr();
        wa.delete();
        wd.delete();
        sb.delete();
        sl.delete();
        wr_cyc = -1;
        done_cyc = -1;
        acc_cyc = -1;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drive(input int gap, input int start_at, input int budget);
        int idx = 0;
        int n = 0;
        bit v;
        while (!done && n < budget) begin
            @(negedge clk);
            if (done) break;
            v = (idx < sb.size()) && ($urandom_range(0, 99) >= gap);
            in_valid = v;
            if (v) begin
                in_data = sb[idx];
                in_last = sl[idx];
            end else begin
                in_data = 8'($urandom);
                in_last = 1'($urandom);
            end
            start = (n == start_at);
            if (v && in_ready) begin
                idx++;
                acc_cyc = cyc_cnt;
            end
            n++;
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        start = 1'b0;
        #1;
        check("done_reached", 64'(done), 64'd1);
    endtask

    task automatic verify(input string t);
        check({t, ":nwr"}, 64'(wa.size()), 64'(ea.size()));
        for (int i = 0; i < ea.size() && i < wa.size(); i++) begin
            check({t, ":addr"}, 64'(wa[i]), 64'(ea[i]));
            check({t, ":data"}, 64'(wd[i]), 64'(ed[i]));
        end
        check({t, ":done"}, 64'(done), 64'd1);
        check({t, ":error"}, 64'(error), 64'(e_err));
        check({t, ":wc"}, 64'(word_count), 64'(e_wc));
        check({t, ":busy"}, 64'(busy), 64'd0);
        check({t, ":rdy"}, 64'(in_ready), 64'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset_outs", 64'({in_ready, wr_en, wr_addr, wr_data, busy,
                                 done, error, word_count}), 64'd0);
        nReset = 1'b1;

        // Valid bytes in IDLE must not be taken
        clr();
        @(negedge clk);
        in_valid = 1'b1;
        in_data = 8'h99;
        in_last = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_rdy", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        in_last = 1'b0;
        #1;
        check("idle_nwr", 64'(wa.size()), 64'd0);

        // Single word, valid held high
        clr();
        sb = '{8'h12, 8'h34, 8'h56};
        sl = '{1'b0, 1'b0, 1'b1};
        model();
        pulse_start();
        drive(0, -1, 100);
        verify("t1");
        check("t1_wr_lat", 64'(wr_cyc - acc_cyc), 64'd1);
        check("t1_done_lat", 64'(done_cyc - acc_cyc), 64'd2);

        // Three words with gaps; start pulse inside LOAD ignored
        clr();
        sb = '{8'hAA, 8'hBB, 8'hCC, 8'h01, 8'h02, 8'h03,
               8'hFF, 8'hEE, 8'hDD};
        sl = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
        model();
        pulse_start();
        drive(40, 2, 400);
        verify("t2");

        // Fill the whole memory without a last marker
        clr();
        for (int i = 0; i < DEPTH * BYTES; i++) begin
            sb.push_back(8'($urandom));
            sl.push_back(1'b0);
        end
        model();
        pulse_start();
        drive(20, -1, 3000);
        verify("t3");
        check("t3_addr_wrap", 64'(wr_addr), 64'd0);
        repeat (3) @(negedge clk);
        check("t3_rdy_after", 64'(in_ready), 64'd0);

        // Last marker mid-word
        clr();
        for (int i = 0; i < 5; i++) begin
            sb.push_back(8'($urandom));
            sl.push_back(i == 4);
        end
        model();
        pulse_start();
        drive(30, -1, 200);
        verify("t4");

        // Restart from DONE clears status
        clr();
        pulse_start();
        #1;
        check("rs_done", 64'(done), 64'd0);
        check("rs_error", 64'(error), 64'd0);
        check("rs_wc", 64'(word_count), 64'd0);
        check("rs_addr", 64'(wr_addr), 64'd0);
        check("rs_busy", 64'(busy), 64'd1);

        // Reset in the middle of a word
        @(negedge clk);
        in_valid = 1'b1;
        in_data = 8'h11;
        @(negedge clk);
        in_valid = 1'b0;
        nReset = 1'b0;
        #1;
        check("mid_reset_outs", 64'({in_ready, wr_en, wr_addr, wr_data, busy,
                                     done, error, word_count}), 64'd0);
        repeat (3) @(negedge clk);
        nReset = 1'b1;
        #1;
        check("mid_reset_nwr", 64'(wa.size()), 64'd0);

        // Fresh load after reset
        clr();
        for (int i = 0; i < BYTES; i++) begin
            sb.push_back(8'($urandom));
            sl.push_back(i == BYTES - 1);
        end
        model();
        pulse_start();
        drive(25, -1, 200);
        verify("t5");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
